// File: rtl/addsub_pkg.sv
// Shared types and limits for the pipelined add/subtract unit.
// Optional clamp-on-overflow build: ADDSUB_SATURATE_EN.
package addsub_pkg;

   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} addsub_op_e;

   localparam int unsigned MAX_LATENCY = 4;
   localparam int unsigned MIN_W       = 2;

   // Per-stage status bits; the result payload itself rides next to this.
   localparam int unsigned RES_OVF_BIT   = 0;
   localparam int unsigned RES_CARRY_BIT = 1;
   localparam int unsigned RES_VALID_BIT = 2;
   localparam int unsigned RES_FLAGS_W   = 3;

   typedef struct packed {
      logic valid;
      logic carry;
      logic ovf;
   } res_flags_t;

endpackage

// File: rtl/addsub_pipe_stage.sv
// One valid/ready register slice carrying a finished result, its flags and tag.
module addsub_pipe_stage
   import addsub_pkg::*;
#(
   parameter int unsigned W     = 20,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_y,
   input  logic             in_carry,
   input  logic             in_ovf,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_y,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   res_flags_t       flags_q;
   logic [W-1:0]     y_q;
   logic [TAG_W-1:0] tag_q;

   // Load when empty or when the current beat leaves this cycle.
   assign in_ready = !flags_q.valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
         y_q     <= '0;
         tag_q   <= '0;
      end else if (in_ready) begin
         flags_q.valid <= in_valid;
         if (in_valid) begin
            flags_q.carry <= in_carry;
            flags_q.ovf   <= in_ovf;
            y_q           <= in_y;
            tag_q         <= in_tag;
         end
      end
   end

   assign out_valid = flags_q.valid;
   assign out_carry = flags_q.carry;
   assign out_ovf   = flags_q.ovf;
   assign out_y     = y_q;
   assign out_tag   = tag_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined W-bit add/subtract with carry/borrow, signed overflow and tag sideband.
// Define ADDSUB_SATURATE_EN to clamp results on signed overflow.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int unsigned W       = 20,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     y,
   output logic             carry,
   output logic             ovf,
   output logic [TAG_W-1:0] out_tag
);

   addsub_op_e   op_e;
   logic [W-1:0] b_eff;
   logic [W:0]   sum;
   logic [W-1:0] y_res;
   logic         c_res;
   logic         o_res;

   assign op_e = addsub_op_e'(op);

   // Subtract as a + ~b + 1; the carry out inverted is the unsigned borrow.
   always_comb begin
      b_eff = (op_e == OP_SUB) ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + (W+1)'(op_e == OP_SUB);
      c_res = (op_e == OP_SUB) ? ~sum[W] : sum[W];
      o_res = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
      y_res = sum[W-1:0];
`ifdef ADDSUB_SATURATE_EN
      if (o_res) begin
         y_res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
`endif
   end

   logic             vld  [LATENCY];
   logic [W-1:0]     ys   [LATENCY];
   logic             cs   [LATENCY];
   logic             os   [LATENCY];
   logic [TAG_W-1:0] tags [LATENCY];
   logic             rdy  [1:LATENCY];

   res_flags_t       s0_q;
   logic [W-1:0]     y0_q;
   logic [TAG_W-1:0] tag0_q;

   assign rdy[LATENCY] = out_ready;
   assign in_ready     = !s0_q.valid || rdy[1];

   // Compute stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q   <= '0;
         y0_q   <= '0;
         tag0_q <= '0;
      end else if (in_ready) begin
         s0_q.valid <= in_valid;
         if (in_valid) begin
            s0_q.carry <= c_res;
            s0_q.ovf   <= o_res;
            y0_q       <= y_res;
            tag0_q     <= in_tag;
         end
      end
   end

   assign vld[0]  = s0_q.valid;
   assign cs[0]   = s0_q.carry;
   assign os[0]   = s0_q.ovf;
   assign ys[0]   = y0_q;
   assign tags[0] = tag0_q;

   for (genvar k = 1; k < LATENCY; k++) begin : g_stage
      addsub_pipe_stage #(
         .W     (W),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (vld[k-1]),
         .in_ready  (rdy[k]),
         .in_y      (ys[k-1]),
         .in_carry  (cs[k-1]),
         .in_ovf    (os[k-1]),
         .in_tag    (tags[k-1]),
         .out_valid (vld[k]),
         .out_ready (rdy[k+1]),
         .out_y     (ys[k]),
         .out_carry (cs[k]),
         .out_ovf   (os[k]),
         .out_tag   (tags[k])
      );
   end

   assign out_valid = vld[LATENCY-1];
   assign y         = ys[LATENCY-1];
   assign carry     = cs[LATENCY-1];
   assign ovf       = os[LATENCY-1];
   assign out_tag   = tags[LATENCY-1];

endmodule
